// File: rtl/imem_loader.sv
// Packs the UART byte stream (4-byte LE length header, then program bytes) into
// 32-bit little-endian words and writes them sequentially into instruction memory.
module imem_loader #(
    parameter int ADDR_W    = 12,
    parameter int BASE_ADDR = 0,
    parameter int MEM_WORDS = 4096
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              Rdata_valid,
    input  logic [7:0]        receive_data,
    input  logic              Receive_fin,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic [31:0]       load_len,
    output logic [7:0]        checksum,
    output logic              load_done,
    output logic              ovf_err
);

    localparam logic [ADDR_W-1:0] BASE    = ADDR_W'(BASE_ADDR);
    localparam logic [31:0]       MEM_LIM = 32'(MEM_WORDS);

    typedef enum logic [1:0] {S_LEN, S_DATA, S_FLUSH, S_DONE} state_t;

    state_t      state, state_nxt;
    logic [1:0]  hdr_cnt;
    logic [1:0]  lane;
    logic [23:0] asm_q;     // lanes 0..2; lane 3 goes straight into the write word
    logic [31:0] word_cnt;

    logic        take_hdr, take_byte, word_full, wr_req, wr_ok;
    logic [31:0] word_nxt;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= S_LEN;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_LEN:   if (Rdata_valid && hdr_cnt == 2'd3) state_nxt = S_DATA;
            // a byte arriving with Receive_fin is consumed first; fin is seen next cycle
            S_DATA:  if (Receive_fin && !Rdata_valid)
                         state_nxt = (lane != 2'd0) ? S_FLUSH : S_DONE;
            S_FLUSH: state_nxt = S_DONE;
            S_DONE:  state_nxt = S_DONE;
            default: state_nxt = S_LEN;
        endcase
    end

    always_comb begin
        take_hdr  = (state == S_LEN)  && Rdata_valid;
        take_byte = (state == S_DATA) && Rdata_valid;
        word_full = take_byte && (lane == 2'd3);
        wr_req    = word_full || (state == S_FLUSH);
        wr_ok     = wr_req && (word_cnt < MEM_LIM);
        word_nxt  = (state == S_FLUSH) ? {8'h00, asm_q} : {receive_data, asm_q};
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            imem_we    <= 1'b0;
            imem_addr  <= BASE;
            imem_wdata <= '0;
            load_len   <= '0;
            checksum   <= '0;
            load_done  <= 1'b0;
            ovf_err    <= 1'b0;
            hdr_cnt    <= '0;
            lane       <= '0;
            asm_q      <= '0;
            word_cnt   <= '0;
        end else begin
            imem_we <= wr_ok;
            if (take_hdr) begin
                load_len <= {receive_data, load_len[31:8]};
                hdr_cnt  <= hdr_cnt + 2'd1;
            end
            if (take_byte) begin
                checksum <= checksum ^ receive_data;
                lane     <= lane + 2'd1;
                case (lane)
                    2'd0:    asm_q[7:0]   <= receive_data;
                    2'd1:    asm_q[15:8]  <= receive_data;
                    2'd2:    asm_q[23:16] <= receive_data;
                    default: ;
                endcase
            end
            // Suppressed writes still advance the word count so later words stay suppressed
            if (wr_req) begin
                asm_q    <= '0;
                word_cnt <= word_cnt + 32'd1;
                if (wr_ok) begin
                    imem_wdata <= word_nxt;
                    imem_addr  <= BASE + word_cnt[ADDR_W-1:0];
                end else begin
                    ovf_err <= 1'b1;
                end
            end
            if (state == S_DONE) load_done <= 1'b1;
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: a full-size instance and a 2-word instance at a
// non-zero base share stimulus; a byte-level model queues the expected writes of each.
module tb_imem_loader;

    localparam int AW  = 12;
    localparam int SB  = 3;
    localparam int SW  = 2;
    localparam int BW  = 4096;
    localparam int GAP = 10;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          rv = 1'b0;
    logic          fin = 1'b0;
    logic [7:0]    rd = 8'h00;

    logic          we_a, we_b, done_a, done_b, ovf_a, ovf_b;
    logic [AW-1:0] addr_a, addr_b;
    logic [31:0]   wd_a, wd_b, len_a, len_b;
    logic [7:0]    cks_a, cks_b;

    always #5 clk = ~clk;

    imem_loader #(.ADDR_W(AW), .BASE_ADDR(0), .MEM_WORDS(BW)) dut (
        .CLK(clk), .RST(rst), .Rdata_valid(rv), .receive_data(rd), .Receive_fin(fin),
        .imem_we(we_a), .imem_addr(addr_a), .imem_wdata(wd_a), .load_len(len_a),
        .checksum(cks_a), .load_done(done_a), .ovf_err(ovf_a));

    imem_loader #(.ADDR_W(AW), .BASE_ADDR(SB), .MEM_WORDS(SW)) dut_s (
        .CLK(clk), .RST(rst), .Rdata_valid(rv), .receive_data(rd), .Receive_fin(fin),
        .imem_we(we_b), .imem_addr(addr_b), .imem_wdata(wd_b), .load_len(len_b),
        .checksum(cks_b), .load_done(done_b), .ovf_err(ovf_b));

    int n_run = 0;
    int n_fail = 0;

    logic [AW+31:0] exp_a[$];
    logic [AW+31:0] exp_b[$];

    int          m_phase, m_hcnt, m_lane, m_idx;
    logic [31:0] m_acc, m_len;
    logic [7:0]  m_cks;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    logic prev_a = 1'b0;
    logic prev_b = 1'b0;

    always @(negedge clk) begin
        logic [AW+31:0] e;
        if (we_a) begin
            chk("we_b2b_a", 32'(prev_a), 32'd0);
            if (exp_a.size() == 0) chk("spur_we_a", 32'(we_a), 32'd0);
            else begin
                e = exp_a.pop_front();
                chk("addr_a", 32'(addr_a), 32'(e[AW+31:32]));
                chk("data_a", wd_a, e[31:0]);
            end
        end
        if (we_b) begin
            chk("we_b2b_b", 32'(prev_b), 32'd0);
            if (exp_b.size() == 0) chk("spur_we_b", 32'(we_b), 32'd0);
            else begin
                e = exp_b.pop_front();
                chk("addr_b", 32'(addr_b), 32'(e[AW+31:32]));
                chk("data_b", wd_b, e[31:0]);
            end
        end
        prev_a <= we_a;
        prev_b <= we_b;
    end

    task automatic model_reset();
        m_phase = 0; m_hcnt = 0; m_lane = 0; m_idx = 0;
        m_acc = '0; m_len = '0; m_cks = '0;
    endtask

    task automatic push_word(input logic [31:0] w);
        if (m_idx < BW) exp_a.push_back({AW'(m_idx), w});
        if (m_idx < SW) exp_b.push_back({AW'(SB + m_idx), w});
        m_idx++;
    endtask

    task automatic model_fin();
        if (m_phase == 1) begin
            if (m_lane != 0) push_word(m_acc);
            m_phase = 2;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; rv = 1'b0; fin = 1'b0; rd = 8'h00;
        #1;
        chk("rst_we",   32'(we_a),   32'd0);
        chk("rst_addr", 32'(addr_a), 32'd0);
        chk("rst_addr_s", 32'(addr_b), 32'(SB));
        chk("rst_wdata", wd_a, 32'd0);
        chk("rst_len",  len_a, 32'd0);
        chk("rst_cks",  32'(cks_a),  32'd0);
        chk("rst_done", 32'(done_a), 32'd0);
        chk("rst_ovf",  32'(ovf_b),  32'd0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic send_byte(input logic [7:0] b, input logic with_fin);
        logic ew_a, ew_b;
        ew_a = 1'b0; ew_b = 1'b0;
        @(negedge clk);
        rv = 1'b1; rd = b;
        if (with_fin) fin = 1'b1;
        if (m_phase == 0) begin
            m_len = {b, m_len[31:8]};
            m_hcnt++;
            if (m_hcnt == 4) m_phase = 1;
        end else if (m_phase == 1) begin
            m_cks ^= b;
            m_acc[8*m_lane +: 8] = b;
            if (m_lane == 3) begin
                ew_a = (m_idx < BW);
                ew_b = (m_idx < SW);
                push_word(m_acc);
                m_acc = '0;
                m_lane = 0;
            end else m_lane++;
        end
        if (with_fin) model_fin();
        @(negedge clk);
        rv = 1'b0;
        chk("lat_a", 32'(we_a), 32'(ew_a));
        chk("lat_b", 32'(we_b), 32'(ew_b));
        repeat (GAP) @(negedge clk);
    endtask

    task automatic send_header(input logic [31:0] l);
        for (int k = 0; k < 4; k++) send_byte(l[8*k +: 8], 1'b0);
    endtask

    task automatic finish_load();
        int t;
        model_fin();
        @(negedge clk);
        fin = 1'b1;
        t = 0;
        while (!(done_a && done_b) && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("done_a", 32'(done_a), 32'd1);
        chk("done_b", 32'(done_b), 32'd1);
        chk("q_empty_a", exp_a.size(), 32'd0);
        chk("q_empty_b", exp_b.size(), 32'd0);
        chk("len_a", len_a, m_len);
        chk("cks_a", 32'(cks_a), 32'(m_cks));
        chk("cks_b", 32'(cks_b), 32'(m_cks));
        chk("ovf_a", 32'(ovf_a), 32'(m_idx > BW));
        chk("ovf_b", 32'(ovf_b), 32'(m_idx > SW));
    endtask

    task automatic load_image(input logic [7:0] img[$], input logic fin_last);
        send_header(img.size());
        for (int i = 0; i < img.size(); i++)
            send_byte(img[i], fin_last && (i == img.size() - 1));
        finish_load();
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout: run did not complete");
        $fatal(1);
    end

    initial begin
        logic [7:0] img1[$];
        logic [7:0] img2[$];
        logic [7:0] img4[$];
        img1 = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        img2 = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        for (int i = 0; i < 12; i++) img4.push_back(8'($urandom_range(0, 255)));
        model_reset();

        // image 1: two full words
        do_reset();
        load_image(img1, 1'b0);
        chk("t1_cks_abs", 32'(cks_a), 32'h90);
        chk("t1_len_abs", len_a, 32'd8);

        // image 2: partial last word flushed; fin arrives with the last byte
        do_reset();
        load_image(img2, 1'b1);

        // zero-length image with fin already high during the header
        do_reset();
        fin = 1'b1;
        send_header(32'd0);
        finish_load();

        // 12 bytes: overflows the 2-word instance only
        do_reset();
        load_image(img4, 1'b0);
        chk("t4_ovf_s", 32'(ovf_b), 32'd1);

        // reset mid-load after the 5th program byte, then reload image 1
        do_reset();
        send_header(32'd8);
        for (int i = 0; i < 5; i++) send_byte(img1[i], 1'b0);
        do_reset();
        load_image(img1, 1'b0);

        // bytes after load_done are ignored
        for (int i = 0; i < 3; i++) send_byte(8'hA5 + 8'(i), 1'b0);
        chk("t6_cks", 32'(cks_a), 32'(m_cks));
        chk("t6_len", len_a, 32'd8);
        chk("t6_done", 32'(done_a), 32'd1);
        chk("t6_q", exp_a.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
